// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 exception requester: ExcCodes, status enable
// bit positions, sequencer states, exc_signal encodings and the sync priority pick.
package cp0_pkg;

  localparam logic [3:0] EXC_INT = 4'd0;
  localparam logic [3:0] EXC_SYS = 4'd8;
  localparam logic [3:0] EXC_BP  = 4'd9;
  localparam logic [3:0] EXC_OV  = 4'd12;
  localparam logic [3:0] EXC_TR  = 4'd13;

  localparam int EN_INT = 0;
  localparam int EN_SYS = 1;
  localparam int EN_BP  = 2;
  localparam int EN_TR  = 3;
  localparam int EN_OV  = 4;

  localparam int FLAG_SYS = 0;
  localparam int FLAG_BP  = 1;
  localparam int FLAG_TR  = 2;
  localparam int FLAG_OV  = 3;

  localparam logic [1:0] SIG_NONE   = 2'b00;
  localparam logic [1:0] SIG_ENTRY  = 2'b10;
  localparam logic [1:0] SIG_RETURN = 2'b01;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTER   = 2'd1,
    HANDLER = 2'd2,
    RETURN  = 2'd3
  } exc_state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] code;
  } exc_req_t;

  // Highest-priority enabled synchronous exception: Ov, Tr, Sys, Bp.
  function automatic exc_req_t pick_sync(input logic [3:0] flags, input logic [4:0] en);
    exc_req_t req;
    req.hit  = 1'b1;
    req.code = EXC_INT;
    if (flags[FLAG_OV] && en[EN_OV])        req.code = EXC_OV;
    else if (flags[FLAG_TR] && en[EN_TR])   req.code = EXC_TR;
    else if (flags[FLAG_SYS] && en[EN_SYS]) req.code = EXC_SYS;
    else if (flags[FLAG_BP] && en[EN_BP])   req.code = EXC_BP;
    else                                    req.hit  = 1'b0;
    return req;
  endfunction

endpackage

// File: rtl/cp0_irq_latch.sv
// Pending hardware-interrupt register: level-set bits, cleared one at a time
// (lowest-numbered first) when the sequencer takes an interrupt.
module cp0_irq_latch
  import cp0_pkg::*;
(
  input  logic       clock_in,
  input  logic       reset,
  input  logic [5:0] irq,
  input  logic       take,
  output logic       any_pending
);

  logic [5:0] pending;
  logic [5:0] lowest;

  // Two's-complement trick isolates the lowest set bit.
  assign lowest      = pending & (~pending + 6'd1);
  assign any_pending = |pending;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~(take ? lowest : 6'd0)) | irq;
    end
  end

endmodule

// File: rtl/cp0_exc_requester.sv
// Exception/interrupt request sequencer feeding CP0 exc_signal, cause and pc.
// Define CP0_IRQ_EN to compile in the interrupt pending register and Int path.
module cp0_exc_requester
  import cp0_pkg::*;
(
  input  logic        clock_in,
  input  logic        reset,
  input  logic        inst_valid,
  input  logic [31:0] inst_pc,
  input  logic [3:0]  exc_flags,
  input  logic        eret,
  input  logic [5:0]  irq,
  input  logic [31:0] status,
  output logic [1:0]  exc_signal,
  output logic [3:0]  cause,
  output logic [31:0] exc_pc,
  output logic        stall,
  output logic        flush,
  output logic        exc_dropped
);

  exc_state_e  state;
  exc_req_t    sync_req;
  logic        irq_req;
  logic [31:0] int_pc;

  assign sync_req = pick_sync(inst_valid ? exc_flags : 4'b0000, status[4:0]);

`ifdef CP0_IRQ_EN
  logic        irq_any;
  logic        irq_take;
  logic [31:0] last_pc;
  logic        unused_status;

  assign unused_status = ^status[31:5];
  assign irq_req  = irq_any && status[EN_INT];
  // Int is lowest priority: only taken when no synchronous exception wins.
  assign irq_take = (state == IDLE) && !sync_req.hit && irq_req;
  assign int_pc   = inst_valid ? inst_pc : last_pc;

  cp0_irq_latch u_irq_latch (
    .clock_in    (clock_in),
    .reset       (reset),
    .irq         (irq),
    .take        (irq_take),
    .any_pending (irq_any)
  );

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset)          last_pc <= '0;
    else if (inst_valid) last_pc <= inst_pc;
  end
`else
  logic unused_inputs;

  assign unused_inputs = ^{irq, status[31:5], status[EN_INT]};
  assign irq_req       = 1'b0;
  assign int_pc        = '0;
`endif

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      exc_signal  <= SIG_NONE;
      cause       <= '0;
      exc_pc      <= '0;
      stall       <= 1'b0;
      flush       <= 1'b0;
      exc_dropped <= 1'b0;
    end else begin
      // Pulse outputs default low; cause/exc_pc hold their last latched value.
      exc_signal  <= SIG_NONE;
      stall       <= 1'b0;
      flush       <= 1'b0;
      exc_dropped <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sync_req.hit) begin
            state      <= ENTER;
            exc_signal <= SIG_ENTRY;
            stall      <= 1'b1;
            flush      <= 1'b1;
            cause      <= sync_req.code;
            exc_pc     <= inst_pc;
          end else if (irq_req) begin
            state      <= ENTER;
            exc_signal <= SIG_ENTRY;
            stall      <= 1'b1;
            flush      <= 1'b1;
            cause      <= EXC_INT;
            exc_pc     <= int_pc;
          end
        end
        ENTER: state <= HANDLER;
        HANDLER: begin
          // No nesting: an enabled sync request here is discarded, even alongside eret.
          exc_dropped <= sync_req.hit;
          if (eret) begin
            state      <= RETURN;
            exc_signal <= SIG_RETURN;
            stall      <= 1'b1;
            flush      <= 1'b1;
          end
        end
        RETURN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_requester.sv
// Self-checking bench for cp0_exc_requester: directed cases plus randomized
// traffic against a behavioural model; honours CP0_IRQ_EN like the design.
`timescale 1ns/1ps
module tb_cp0_exc_requester;

  logic        clock_in = 1'b0;
  logic        reset = 1'b0;
  logic        inst_valid = 1'b0;
  logic [31:0] inst_pc = '0;
  logic [3:0]  exc_flags = '0;
  logic        eret = 1'b0;
  logic [5:0]  irq = '0;
  logic [31:0] status = '0;
  logic [1:0]  exc_signal;
  logic [3:0]  cause;
  logic [31:0] exc_pc;
  logic        stall;
  logic        flush;
  logic        exc_dropped;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: expected registered outputs plus what the handler knows.
  logic [1:0]  m_sig;
  logic [3:0]  m_cause;
  logic [31:0] m_pc;
  bit          m_drop;
  bit          m_in_handler;
  logic [5:0]  m_pend;
  logic [31:0] m_last_pc;

  // Priority table, highest first: Ov, Tr, Sys, Bp.
  int pr_code [4] = '{12, 13, 8, 9};
  int pr_flag [4] = '{3, 2, 0, 1};
  int pr_en   [4] = '{4, 3, 1, 2};

  cp0_exc_requester dut (
    .clock_in    (clock_in),
    .reset       (reset),
    .inst_valid  (inst_valid),
    .inst_pc     (inst_pc),
    .exc_flags   (exc_flags),
    .eret        (eret),
    .irq         (irq),
    .status      (status),
    .exc_signal  (exc_signal),
    .cause       (cause),
    .exc_pc      (exc_pc),
    .stall       (stall),
    .flush       (flush),
    .exc_dropped (exc_dropped)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sig = 2'b00; m_cause = '0; m_pc = '0; m_drop = 0;
    m_in_handler = 0; m_pend = '0; m_last_pc = '0;
  endtask

  task automatic model_step();
    logic [3:0] fl;
    logic [5:0] take_mask;
    bit         hit;
    int         code;
    fl = inst_valid ? exc_flags : 4'b0000;
    hit = 0; code = 0; take_mask = '0;
    for (int i = 0; i < 4; i++)
      if (!hit && fl[pr_flag[i]] && status[pr_en[i]]) begin
        hit = 1; code = pr_code[i];
      end
    m_drop = 0;
    if (m_sig == 2'b10) begin
      m_sig = 2'b00; m_in_handler = 1;
    end else if (m_sig == 2'b01) begin
      m_sig = 2'b00; m_in_handler = 0;
    end else if (m_in_handler) begin
      m_drop = hit;
      if (eret) m_sig = 2'b01;
    end else if (hit) begin
      m_sig = 2'b10; m_cause = 4'(code); m_pc = inst_pc;
    end
`ifdef CP0_IRQ_EN
    else if (status[0] && m_pend != 0) begin
      m_sig = 2'b10; m_cause = 4'd0;
      m_pc = inst_valid ? inst_pc : m_last_pc;
      for (int b = 0; b < 6; b++)
        if (take_mask == 0 && m_pend[b]) take_mask[b] = 1'b1;
    end
    m_pend = (m_pend & ~take_mask) | irq;
    if (inst_valid) m_last_pc = inst_pc;
`endif
  endtask

  task automatic compare_all();
    check("exc_signal", 32'(exc_signal), 32'(m_sig));
    check("cause", 32'(cause), 32'(m_cause));
    check("exc_pc", exc_pc, m_pc);
    check("stall", 32'(stall), 32'(m_sig != 2'b00));
    check("flush", 32'(flush), 32'(m_sig != 2'b00));
    check("exc_dropped", 32'(exc_dropped), 32'(m_drop));
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [3:0] fl,
                       input bit er, input logic [5:0] iq, input logic [31:0] st);
    inst_valid = v; inst_pc = pc; exc_flags = fl; eret = er; irq = iq; status = st;
  endtask

  // Inputs are changed at negedge; the model advances at posedge; outputs checked at negedge.
  task automatic cycle();
    @(posedge clock_in);
    model_step();
    @(negedge clock_in);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(0, '0, '0, 0, '0, '0);
    model_reset();
    repeat (2) @(negedge clock_in);
    reset = 1'b1;
  endtask

  task automatic finish_handler();
    drive(0, '0, '0, 0, '0, '0); cycle();
    drive(0, '0, '0, 1, '0, '0); cycle();
    drive(0, '0, '0, 0, '0, '0); cycle();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock_in);
    check("reset_sig", 32'(exc_signal), 32'd0);
    check("reset_pc", exc_pc, 32'd0);
    reset = 1'b1;

    // Reset asserted in the middle of the ENTER pulse.
    drive(1, 32'h0040_0010, 4'b0001, 0, '0, 32'h0000_000f);
    @(posedge clock_in);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_sig", 32'(exc_signal), 32'd0);
    check("rst_mid_cause", 32'(cause), 32'd0);
    check("rst_mid_pc", exc_pc, 32'd0);
    check("rst_mid_stall", 32'({stall, flush, exc_dropped}), 32'd0);
    do_reset();
    drive(0, '0, '0, 0, '0, '0); cycle();
    check("post_rst_idle", 32'(exc_signal), 32'd0);

    // Syscall entry.
    drive(1, 32'h0040_0020, 4'b0001, 0, '0, 32'h0000_000f); cycle();
    check("sys_sig", 32'(exc_signal), 32'h2);
    check("sys_cause", 32'(cause), 32'd8);
    check("sys_pc", exc_pc, 32'h0040_0020);
    check("sys_stall_flush", 32'({stall, flush}), 32'h3);
    drive(0, '0, '0, 0, '0, '0); cycle();
    check("sys_one_cycle", 32'(exc_signal), 32'd0);
    // Break in handler with its enable forced on: dropped only.
    drive(1, 32'h0040_0024, 4'b0010, 0, '0, 32'h0000_0004); cycle();
    check("hdl_drop", 32'(exc_dropped), 32'd1);
    check("hdl_no_entry", 32'(exc_signal), 32'd0);
    drive(0, '0, '0, 1, '0, '0); cycle();
    check("eret_sig", 32'(exc_signal), 32'h1);
    check("eret_stall", 32'({stall, flush}), 32'h3);
    drive(0, '0, '0, 0, '0, '0); cycle();
    check("eret_done", 32'(exc_signal), 32'd0);

    // Ov beats Sys.
    drive(1, 32'h0040_0030, 4'b1001, 0, '0, 32'h0000_001f); cycle();
    check("ov_prio_cause", 32'(cause), 32'd12);
    finish_handler();

    // Masked Ov: ignored silently.
    drive(1, 32'h0040_0040, 4'b1000, 0, '0, 32'h0000_000f); cycle();
    check("ov_masked_sig", 32'(exc_signal), 32'd0);
    check("ov_masked_drop", 32'(exc_dropped), 32'd0);

    // eret and exception together in HANDLER: eret wins, exception dropped.
    drive(1, 32'h0040_0050, 4'b0100, 0, '0, 32'h0000_000f); cycle();
    drive(0, '0, '0, 0, '0, '0); cycle();
    drive(1, 32'h0040_0054, 4'b0100, 1, '0, 32'h0000_0008); cycle();
    check("race_sig", 32'(exc_signal), 32'h1);
    check("race_drop", 32'(exc_dropped), 32'd1);
    // Request during RETURN waits for the first IDLE cycle.
    drive(1, 32'h0040_0058, 4'b0001, 0, '0, 32'h0000_000f); cycle();
    check("ret_no_accept", 32'(exc_signal), 32'd0);
    cycle();
    check("b2b_accept", 32'(exc_signal), 32'h2);
    finish_handler();

`ifdef CP0_IRQ_EN
    do_reset();
    drive(1, 32'h0040_0100, 4'b0000, 0, 6'b000100, 32'h0); cycle();
    drive(0, '0, '0, 0, 6'b000000, 32'h0); cycle();
    check("irq_masked", 32'(exc_signal), 32'd0);
    check("irq_pending", 32'(dut.u_irq_latch.pending), 32'h4);
    drive(0, '0, '0, 0, 6'b000000, 32'h1); cycle();
    check("irq_sig", 32'(exc_signal), 32'h2);
    check("irq_cause", 32'(cause), 32'd0);
    check("irq_pc", exc_pc, 32'h0040_0100);
    check("irq_cleared", 32'(dut.u_irq_latch.pending), 32'h0);
    finish_handler();
`else
    do_reset();
    drive(0, '0, '0, 0, 6'b111111, 32'h1); cycle();
    drive(0, '0, '0, 0, 6'b000000, 32'h1); cycle();
    check("irq_ignored", 32'(exc_signal), 32'd0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [3:0]  fl;
      logic [5:0]  iq;
      logic [31:0] st;
      fl = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      iq = ($urandom_range(0, 15) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'b0;
      st = {$urandom, 5'b0} | 32'($urandom_range(0, 31));
      drive(($urandom_range(0, 1) == 1), {$urandom} & 32'hffff_fffc, fl,
            ($urandom_range(0, 3) == 0), iq, st);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_exc_requester.md
# cp0_exc_requester

Exception/interrupt request sequencer that drives the CP0 register file's `exc_signal`, `cause` and `pc` inputs. It sits between the decode/execute stages and CP0.
- Collects synchronous exception flags and external interrupt lines, and qualifies them against the CP0 status enable field.
- Issues exactly one entry pulse per accepted exception and one return pulse per `eret`.
- Stalls and flushes the pipeline around each transition and blocks nesting while a handler runs.

## Interface
- No parameters.
- clock_in  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; all state and outputs are cleared while low.
- inst_valid  in  1  the flags below belong to a live instruction this cycle.
- inst_pc  in  32  PC of that instruction.
- exc_flags  in  4  {ov, teq_trap, brk, syscall}, bits 3..0.
- eret  in  1  a valid `eret` instruction is in execute this cycle.
- irq  in  6  level-sensitive hardware interrupt lines.
- status  in  32  CP0 status word (CP0 `data_out[63:32]`).
- exc_signal  out  2  to CP0: bit1 = exception entry pulse, bit0 = return pulse.
- cause  out  4  ExcCode to CP0.
- exc_pc  out  32  EPC value to CP0.
- stall  out  1  pipeline hold.
- flush  out  1  kill younger instructions.
- exc_dropped  out  1  one-cycle pulse when an enabled request is discarded.

## Operation
- ExcCodes:
  - Int = 0
  - Sys = 8
  - Bp = 9
  - Ov = 12
  - Tr = 13
- Enable bits:
  - status[0]: Int
  - status[1]: Sys
  - status[2]: Bp
  - status[3]: Tr
  - status[4]: Ov
- A source is enabled when its status bit is 1. Masked synchronous flags are ignored silently. Masked interrupts stay pending.
- Priority, highest first: Ov, Tr, Sys, Bp, Int.
- State machine:
  - IDLE: when inst_valid and any enabled flag, or any enabled pending irq, go to ENTER and latch cause plus exc_pc (inst_pc; for Int, the inst_pc of the current valid instruction, or the last valid one if none).
  - ENTER: one cycle. Drives exc_signal=2'b10, stall=1, flush=1. Then go to HANDLER.
  - HANDLER: CP0 has shifted status, so the enables read 0. A new enabled synchronous request pulses exc_dropped and is otherwise discarded. On `eret`, go to RETURN.
  - RETURN: one cycle. Drives exc_signal=2'b01, stall=1, flush=1. Then go to IDLE.
- Pending irq register: each bit is set by its irq level and cleared only when that interrupt is taken (entry with cause Int). Taking an interrupt clears the lowest-numbered pending bit.
- Simultaneous `eret` and exception in HANDLER: `eret` wins and the exception pulses exc_dropped.
- `eret` in IDLE is ignored.

## Timing
- Reset values:
  - exc_signal = 0
  - cause = 0
  - exc_pc = 0
  - stall = 0
  - flush = 0
  - exc_dropped = 0
  - state = IDLE
  - pending irqs = 0
- All outputs are registered and stable for a full cycle, so CP0's negedge sample sees settled values.
- Request sampled at edge k → exc_signal=2'b10 from k to k+1. HANDLER begins at k+1.
- `eret` sampled at edge k → exc_signal=2'b01 from k to k+1.
- An irq asserted at edge k sets pending at k. It can be taken at edge k+1 at the earliest.
- Back-to-back: a request is accepted in the first IDLE cycle after RETURN, never during RETURN itself.
- Reset assertion in ENTER or RETURN aborts the pulse immediately. No partial pulse follows reset release.

## Configuration
- CP0_IRQ_EN defined: irq pending logic and the Int cause path are compiled in.
- CP0_IRQ_EN undefined: the irq port remains but is ignored, there is no pending register, and cause is never 0 from an interrupt.

## Structure
- Package `cp0_pkg` holds:
  - ExcCode constants
  - status enable bit indices
  - the state enum {IDLE, ENTER, HANDLER, RETURN}
  - exc_signal encodings
- Sub-module `cp0_irq_latch` holds the 6-bit pending register with set/clear and the lowest-set-bit selection. It is instantiated only under CP0_IRQ_EN.

## Test plan
- Reset low mid-ENTER → all outputs 0 within the same cycle; state IDLE after release.
- status=0x0000000f, syscall with inst_pc=0x00400020 → one cycle of exc_signal=2'b10, cause=8, exc_pc=0x00400020, stall=flush=1.
- status=0x0000001f, exc_flags=4'b1001 → cause=12 (Ov beats Sys).
- status=0x0000000f, ov alone → no entry, exc_dropped=0.
- In HANDLER: break with status bit2 forced to 1 → exc_dropped pulse only. Then `eret` → exc_signal=2'b01 for one cycle, then IDLE.
- CP0_IRQ_EN defined, irq[2] pulsed while status[0]=0, then status=0x1 → entry with cause=0 on the next cycle; pending[2] cleared.
